ram_port_arbiter: RTL and testbench

Round-robin arbiter that shares the dual-read, single-write block RAM between NUM_REQ requesters (instruction fetch, operand load, store, context save/restore).
- Each cycle it issues up to two reads (RAM read ports 1 and 2) and one write.
- It registers the RAM address and control signals and returns per-requester read data with fixed latency.
- It sits between the CPU pipeline units and the block RAM; it is the only driver of the RAM ports.

---
 rtl/ram_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Summary  : round-robin sharing of a 2-read/1-write block RAM, 2-cycle reads
// Revision : 1.0
// ============================================================================
module ram_port_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int RAM_DEPTH = 700
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [NUM_REQ-1:0]        rsp_err,
    output logic [NUM_REQ*DATA_W-1:0] rsp_data,
    output logic                      ram_write_enabled,
    output logic [ADDR_W-1:0]         ram_write_address,
    output logic [DATA_W-1:0]         ram_write_value,
    output logic [ADDR_W-1:0]         ram_read_address,
    input  logic [DATA_W-1:0]         ram_read_value,
    output logic [ADDR_W-1:0]         ram_read_address2,
    input  logic [DATA_W-1:0]         ram_read_value2
);
    localparam int              c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W:0] c_DEPTH = RAM_DEPTH[ADDR_W:0];

    function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} >= c_DEPTH;
    endfunction

    logic [c_IDX_W-1:0] r_ptr;

    logic               w_rd1_hit, w_rd2_hit, w_wr_hit;
    logic [c_IDX_W-1:0] w_rd1_sel, w_rd2_sel, w_wr_sel, w_next_ptr, w_idx;
    logic [ADDR_W-1:0]  w_rd1_addr, w_rd2_addr, w_wr_addr;
    logic [DATA_W-1:0]  w_wr_data;
    logic [NUM_REQ-1:0] w_gnt;
    int                 w_pos, w_nxt;

    // Scan from the pointer; the last grant seen is the highest scan position,
    // so it alone decides where the next scan starts.
    always_comb begin
        w_rd1_hit  = 1'b0;
        w_rd2_hit  = 1'b0;
        w_wr_hit   = 1'b0;
        w_rd1_sel  = '0;
        w_rd2_sel  = '0;
        w_wr_sel   = '0;
        w_rd1_addr = '0;
        w_rd2_addr = '0;
        w_wr_addr  = '0;
        w_wr_data  = '0;
        w_gnt      = '0;
        w_next_ptr = r_ptr;
        w_idx      = '0;
        w_pos      = 0;
        w_nxt      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = int'(r_ptr) + k;
            if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
            w_idx = c_IDX_W'(w_pos);
            w_nxt = (w_pos == NUM_REQ - 1) ? 0 : w_pos + 1;
            if (req[w_idx]) begin
                if (req_we[w_idx]) begin
                    if (!w_wr_hit) begin
                        w_wr_hit      = 1'b1;
                        w_wr_sel      = w_idx;
                        w_wr_addr     = req_addr[w_pos*ADDR_W +: ADDR_W];
                        w_wr_data     = req_wdata[w_pos*DATA_W +: DATA_W];
                        w_gnt[w_idx]  = 1'b1;
                        w_next_ptr    = c_IDX_W'(w_nxt);
                    end
                end else if (!w_rd1_hit) begin
                    w_rd1_hit     = 1'b1;
                    w_rd1_sel     = w_idx;
                    w_rd1_addr    = req_addr[w_pos*ADDR_W +: ADDR_W];
                    w_gnt[w_idx]  = 1'b1;
                    w_next_ptr    = c_IDX_W'(w_nxt);
                end else if (!w_rd2_hit) begin
                    w_rd2_hit     = 1'b1;
                    w_rd2_sel     = w_idx;
                    w_rd2_addr    = req_addr[w_pos*ADDR_W +: ADDR_W];
                    w_gnt[w_idx]  = 1'b1;
                    w_next_ptr    = c_IDX_W'(w_nxt);
                end
            end
        end
    end

    logic               r_rd1_valid, r_rd2_valid, r_rd1_oor, r_rd2_oor, r_wr_err;
    logic [c_IDX_W-1:0] r_rd1_owner, r_rd2_owner, r_wr_owner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr             <= '0;
            gnt               <= '0;
            r_rd1_valid       <= 1'b0;
            r_rd2_valid       <= 1'b0;
            r_rd1_oor         <= 1'b0;
            r_rd2_oor         <= 1'b0;
            r_wr_err          <= 1'b0;
            r_rd1_owner       <= '0;
            r_rd2_owner       <= '0;
            r_wr_owner        <= '0;
            ram_read_address  <= '0;
            ram_read_address2 <= '0;
            ram_write_enabled <= 1'b0;
            ram_write_address <= '0;
            ram_write_value   <= '0;
        end else begin
            r_ptr             <= w_next_ptr;
            gnt               <= w_gnt;
            r_rd1_valid       <= w_rd1_hit;
            r_rd2_valid       <= w_rd2_hit;
            r_wr_err          <= w_wr_hit && out_of_range(w_wr_addr);
            ram_write_enabled <= w_wr_hit && !out_of_range(w_wr_addr);
            if (w_rd1_hit) begin
                ram_read_address <= w_rd1_addr;
                r_rd1_owner      <= w_rd1_sel;
                r_rd1_oor        <= out_of_range(w_rd1_addr);
            end
            if (w_rd2_hit) begin
                ram_read_address2 <= w_rd2_addr;
                r_rd2_owner       <= w_rd2_sel;
                r_rd2_oor         <= out_of_range(w_rd2_addr);
            end
            if (w_wr_hit) begin
                r_wr_owner        <= w_wr_sel;
                ram_write_address <= w_wr_addr;
                ram_write_value   <= w_wr_data;
            end
        end
    end

    logic [NUM_REQ-1:0]        w_rsp_valid, w_rsp_err;
    logic [NUM_REQ*DATA_W-1:0] w_rsp_data;

    // RAM read data is sampled in the same edge the write commits, which
    // gives read-before-write for same-cycle grants to one address.
    always_comb begin
        w_rsp_valid = '0;
        w_rsp_err   = '0;
        w_rsp_data  = rsp_data;
        if (r_rd1_valid) begin
            if (r_rd1_oor) begin
                w_rsp_err[r_rd1_owner] = 1'b1;
                w_rsp_data[int'(r_rd1_owner)*DATA_W +: DATA_W] = '0;
            end else begin
                w_rsp_valid[r_rd1_owner] = 1'b1;
                w_rsp_data[int'(r_rd1_owner)*DATA_W +: DATA_W] = ram_read_value;
            end
        end
        if (r_rd2_valid) begin
            if (r_rd2_oor) begin
                w_rsp_err[r_rd2_owner] = 1'b1;
                w_rsp_data[int'(r_rd2_owner)*DATA_W +: DATA_W] = '0;
            end else begin
                w_rsp_valid[r_rd2_owner] = 1'b1;
                w_rsp_data[int'(r_rd2_owner)*DATA_W +: DATA_W] = ram_read_value2;
            end
        end
        if (r_wr_err) w_rsp_err[r_wr_owner] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_err   <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= w_rsp_valid;
            rsp_err   <= w_rsp_err;
            rsp_data  <= w_rsp_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// tb_ram_port_arbiter: directed vector table, reset sequence, and random
// traffic compared with a transaction-level model of the arbiter.
module tb_ram_port_arbiter;
    localparam int N = 4, AW = 16, DW = 16, DEPTH = 700;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]          req, req_we;
    logic [N-1:0][AW-1:0]  paddr;
    logic [N-1:0][DW-1:0]  pwd;
    logic [N*AW-1:0]       req_addr;
    logic [N*DW-1:0]       req_wdata;
    logic [N-1:0]          gnt, rsp_valid, rsp_err;
    logic [N*DW-1:0]       rsp_data;
    logic                  ram_write_enabled;
    logic [AW-1:0]         ram_write_address, ram_read_address, ram_read_address2;
    logic [DW-1:0]         ram_write_value, ram_read_value, ram_read_value2;
    logic [DW-1:0]         ram [DEPTH];
    logic [DW-1:0]         shadow [DEPTH];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    assign req_addr  = paddr;
    assign req_wdata = pwd;

    ram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RAM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .rsp_data(rsp_data), .ram_write_enabled(ram_write_enabled),
        .ram_write_address(ram_write_address), .ram_write_value(ram_write_value),
        .ram_read_address(ram_read_address), .ram_read_value(ram_read_value),
        .ram_read_address2(ram_read_address2), .ram_read_value2(ram_read_value2)
    );

    // Block RAM model: combinational reads, synchronous write.
    assign ram_read_value  = (ram_read_address  < AW'(DEPTH)) ? ram[ram_read_address[9:0]]  : '0;
    assign ram_read_value2 = (ram_read_address2 < AW'(DEPTH)) ? ram[ram_read_address2[9:0]] : '0;
    always @(posedge clk)
        if (ram_write_enabled && ram_write_address < AW'(DEPTH))
            ram[ram_write_address[9:0]] <= ram_write_value;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_gnt"}, 64'(gnt), 0);
        chk({name, "_valid"}, 64'(rsp_valid), 0);
        chk({name, "_err"}, 64'(rsp_err), 0);
        chk({name, "_data"}, rsp_data, 0);
        chk({name, "_wen"}, 64'(ram_write_enabled), 0);
        chk({name, "_raddr"}, {ram_read_address, ram_read_address2, ram_write_address}, 0);
    endtask

    typedef struct packed {
        logic [N-1:0]          req, we;
        logic [N-1:0][AW-1:0]  addr;
        logic [N-1:0][DW-1:0]  wd;
        logic [N-1:0]          gnt;
        logic                  wen;
        logic [AW-1:0]         waddr;
        logic [DW-1:0]         wval;
        logic [N-1:0]          valid, err, mask;
        logic [N-1:0][DW-1:0]  data;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [N-1:0] r, input logic [N-1:0] w, input logic [N-1:0][AW-1:0] a,
                       input logic [N-1:0][DW-1:0] d, input logic [N-1:0] g, input logic we,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wv, input logic [N-1:0] v,
                       input logic [N-1:0] e, input logic [N-1:0] m, input logic [N-1:0][DW-1:0] rd);
        vec_t x;
        x = '{req: r, we: w, addr: a, wd: d, gnt: g, wen: we, waddr: wa, wval: wv,
              valid: v, err: e, mask: m, data: rd};
        tbl.push_back(x);
    endtask

    typedef struct packed {
        logic [N-1:0] gnt;
        logic         wen;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wval;
    } port_t;
    typedef struct packed {
        logic [N-1:0]         valid, err, mask;
        logic [N-1:0][DW-1:0] data;
    } rsp_t;
    port_t e1;
    rsp_t  n2, o2;
    int    mptr;
    logic [N-1:0] pend;

    // Reference: first two reads and first write in round-robin order from
    // the pointer; reads see every earlier-granted write, not a same-cycle one.
    task automatic model_step();
        int rd_n, last, i;
        bit wr_done;
        rd_n = 0; last = -1; wr_done = 0;
        e1 = '0; n2 = '0;
        for (int k = 0; k < N; k++) begin
            i = (mptr + k) % N;
            if (!pend[i]) continue;
            if (req_we[i] && !wr_done) begin
                wr_done = 1; last = i; e1.gnt[i] = 1'b1;
                if (paddr[i] < AW'(DEPTH)) begin
                    e1.wen = 1'b1; e1.waddr = paddr[i]; e1.wval = pwd[i];
                end else n2.err[i] = 1'b1;
            end else if (!req_we[i] && rd_n < 2) begin
                rd_n++; last = i; e1.gnt[i] = 1'b1; n2.mask[i] = 1'b1;
                if (paddr[i] < AW'(DEPTH)) begin
                    n2.valid[i] = 1'b1; n2.data[i] = shadow[paddr[i][9:0]];
                end else n2.err[i] = 1'b1;
            end
        end
        if (last >= 0) mptr = (last + 1) % N;
        if (e1.wen) shadow[e1.waddr[9:0]] = e1.wval;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i * 7 + 3);
        ram[100] = 16'h0005;
        rst = 1'b1; req = '0; req_we = '0; paddr = '0; pwd = '0;

        //   req     we      addr {3,2,1,0}                 wdata {3,2,1,0}                       gnt     wen waddr  wval      valid   err     mask    data {3,2,1,0}
        add(4'b1111, 4'b0000, {16'd13,16'd12,16'd11,16'd10}, '0,                                  4'b0011, 0, 16'd0,   16'h0,    4'b0000, 4'b0000, 4'b0000, '0);
        add(4'b1100, 4'b0000, {16'd13,16'd12,16'd0,16'd0},   '0,                                  4'b1100, 0, 16'd0,   16'h0,    4'b0011, 4'b0000, 4'b0011, {16'h0,16'h0,16'h0050,16'h0049});
        add(4'b0000, 4'b0000, '0,                            '0,                                  4'b0000, 0, 16'd0,   16'h0,    4'b1100, 4'b0000, 4'b1100, {16'h005E,16'h0057,16'h0,16'h0});
        add(4'b0000, 4'b0000, '0,                            '0,                                  4'b0000, 0, 16'd0,   16'h0,    4'b0000, 4'b0000, 4'b0000, '0);
        add(4'b0010, 4'b0010, {16'd0,16'd0,16'd300,16'd0},   {16'h0,16'h0,16'h1234,16'h0},        4'b0010, 1, 16'd300, 16'h1234, 4'b0000, 4'b0000, 4'b0000, '0);
        add(4'b0000, 4'b0000, '0,                            '0,                                  4'b0000, 0, 16'd0,   16'h0,    4'b0000, 4'b0000, 4'b0000, '0);
        add(4'b0100, 4'b0000, {16'd0,16'd300,16'd0,16'd0},   '0,                                  4'b0100, 0, 16'd0,   16'h0,    4'b0000, 4'b0000, 4'b0000, '0);
        add(4'b0000, 4'b0000, '0,                            '0,                                  4'b0000, 0, 16'd0,   16'h0,    4'b0100, 4'b0000, 4'b0100, {16'h0,16'h1234,16'h0,16'h0});
        add(4'b1000, 4'b0000, {16'd13,16'd0,16'd0,16'd0},    '0,                                  4'b1000, 0, 16'd0,   16'h0,    4'b0000, 4'b0000, 4'b0000, '0);
        add(4'b0000, 4'b0000, '0,                            '0,                                  4'b0000, 0, 16'd0,   16'h0,    4'b1000, 4'b0000, 4'b1000, {16'h005E,16'h0,16'h0,16'h0});
        add(4'b1001, 4'b1001, {16'd51,16'd0,16'd0,16'd50},   {16'hBBBB,16'h0,16'h0,16'hAAAA},     4'b0001, 1, 16'd50,  16'hAAAA, 4'b0000, 4'b0000, 4'b0000, '0);
        add(4'b1000, 4'b1000, {16'd51,16'd0,16'd0,16'd0},    {16'hBBBB,16'h0,16'h0,16'h0},        4'b1000, 1, 16'd51,  16'hBBBB, 4'b0000, 4'b0000, 4'b0000, '0);
        add(4'b0011, 4'b0000, {16'd0,16'd0,16'd51,16'd50},   '0,                                  4'b0011, 0, 16'd0,   16'h0,    4'b0000, 4'b0000, 4'b0000, '0);
        add(4'b0000, 4'b0000, '0,                            '0,                                  4'b0000, 0, 16'd0,   16'h0,    4'b0011, 4'b0000, 4'b0011, {16'h0,16'h0,16'hBBBB,16'hAAAA});
        add(4'b0011, 4'b0001, {16'd0,16'd0,16'd100,16'd100}, {16'h0,16'h0,16'h0,16'h0009},        4'b0011, 1, 16'd100, 16'h0009, 4'b0000, 4'b0000, 4'b0000, '0);
        add(4'b0000, 4'b0000, '0,                            '0,                                  4'b0000, 0, 16'd0,   16'h0,    4'b0010, 4'b0000, 4'b0010, {16'h0,16'h0,16'h0005,16'h0});
        add(4'b0010, 4'b0000, {16'd0,16'd0,16'd100,16'd0},   '0,                                  4'b0010, 0, 16'd0,   16'h0,    4'b0000, 4'b0000, 4'b0000, '0);
        add(4'b0000, 4'b0000, '0,                            '0,                                  4'b0000, 0, 16'd0,   16'h0,    4'b0010, 4'b0000, 4'b0010, {16'h0,16'h0,16'h0009,16'h0});
        add(4'b1100, 4'b0100, {16'hFFFF,16'd700,16'd0,16'd0},{16'h0,16'hDEAD,16'h0,16'h0},        4'b1100, 0, 16'd0,   16'h0,    4'b0000, 4'b0000, 4'b0000, '0);
        add(4'b0000, 4'b0000, '0,                            '0,                                  4'b0000, 0, 16'd0,   16'h0,    4'b0000, 4'b1100, 4'b1000, '0);
        add(4'b0001, 4'b0000, {16'd0,16'd0,16'd0,16'd699},   '0,                                  4'b0001, 0, 16'd0,   16'h0,    4'b0000, 4'b0000, 4'b0000, '0);
        add(4'b0000, 4'b0000, '0,                            '0,                                  4'b0000, 0, 16'd0,   16'h0,    4'b0001, 4'b0000, 4'b0001, {16'h0,16'h0,16'h0,16'h1320});

        repeat (2) @(posedge clk);
        #1 chk_idle("reset");
        rst = 1'b0;

        foreach (tbl[n]) begin
            v = tbl[n];
            req = v.req; req_we = v.we; paddr = v.addr; pwd = v.wd;
            @(posedge clk); #1;
            chk($sformatf("v%0d_gnt", n), 64'(gnt), 64'(v.gnt));
            chk($sformatf("v%0d_wen", n), 64'(ram_write_enabled), 64'(v.wen));
            if (v.wen) chk($sformatf("v%0d_wport", n), {ram_write_address, ram_write_value}, {v.waddr, v.wval});
            chk($sformatf("v%0d_valid", n), 64'(rsp_valid), 64'(v.valid));
            chk($sformatf("v%0d_err", n), 64'(rsp_err), 64'(v.err));
            for (int i = 0; i < N; i++)
                if (v.mask[i]) chk($sformatf("v%0d_data%0d", n, i), 64'(rsp_data[i*DW +: DW]), 64'(v.data[i]));
        end

        // Reset while two reads and a write are in flight.
        req = 4'b0111; req_we = 4'b0100; paddr = {16'd0, 16'd400, 16'd11, 16'd10}; pwd = {16'h0, 16'h7777, 32'h0};
        @(posedge clk); #1;
        chk("rst_pre_gnt", 64'(gnt), 64'(4'b0111));
        chk("rst_pre_wen", 64'(ram_write_enabled), 1);
        chk("rst_pre_raddr", {ram_read_address, ram_read_address2}, {16'd11, 16'd10});
        req = '0; req_we = '0;
        #2 rst = 1'b1;
        #1 chk_idle("rst_async");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_no_valid", 64'({rsp_valid, rsp_err}), 0);
        end
        req = 4'b1001; paddr = {16'd13, 16'd0, 16'd0, 16'd12};
        @(posedge clk); #1;
        chk("rst_ptr_gnt", 64'(gnt), 64'(4'b1001));
        chk("rst_ptr_ports", {ram_read_address, ram_read_address2}, {16'd12, 16'd13});
        req = '0;
        @(posedge clk); #1;
        chk("rst_ptr_valid", 64'(rsp_valid), 64'(4'b1001));
        chk("rst_ptr_data", {rsp_data[3*DW +: DW], rsp_data[DW-1:0]}, {16'h005E, 16'h0057});
        @(posedge clk); #1;
        chk("idle_hold", {ram_read_address, ram_read_address2}, {16'd12, 16'd13});

        // Random traffic against the reference model.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = ram[i];
        mptr = 0; pend = '0; e1 = '0; n2 = '0; o2 = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            chk("rnd_gnt", 64'(gnt), 64'(e1.gnt));
            chk("rnd_wen", 64'(ram_write_enabled), 64'(e1.wen));
            if (e1.wen) chk("rnd_wport", {ram_write_address, ram_write_value}, {e1.waddr, e1.wval});
            chk("rnd_valid", 64'(rsp_valid), 64'(o2.valid));
            chk("rnd_err", 64'(rsp_err), 64'(o2.err));
            for (int i = 0; i < N; i++)
                if (o2.mask[i]) chk($sformatf("rnd_data%0d", i), 64'(rsp_data[i*DW +: DW]), 64'(o2.data[i]));
            o2 = n2;
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) pend[i] = 1'b0;
                if (!pend[i] && cyc < 396 && $urandom_range(0, 9) < 6) begin
                    pend[i]   = 1'b1;
                    req_we[i] = ($urandom_range(0, 2) == 0);
                    pwd[i]    = DW'($urandom);
                    case ($urandom_range(0, 11))
                        0:       paddr[i] = 16'd700;
                        1:       paddr[i] = 16'hFFFF;
                        default: paddr[i] = AW'(200 + $urandom_range(0, 31));
                    endcase
                end
            end
            req = pend;
            model_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
